// File: rtl/karatsuba_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier between two requesters,
// with a tag pipe for ownership and credit-protected per-requester result FIFOs.
module karatsuba_mul_arbiter #(
   parameter int unsigned XW    = 65,
   parameter int unsigned YW    = 64,
   parameter int unsigned PW    = 129,
   parameter int unsigned LAT   = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req0_valid,
   output logic          o_req0_ready,
   input  logic [XW-1:0] i_req0_x,
   input  logic [YW-1:0] i_req0_y,
   input  logic          i_req1_valid,
   output logic          o_req1_ready,
   input  logic [XW-1:0] i_req1_x,
   input  logic [YW-1:0] i_req1_y,
   output logic [XW-1:0] o_mul_x,
   output logic [YW-1:0] o_mul_y,
   output logic          o_mul_rst,
   input  logic [PW-1:0] i_mul_p,
   output logic          o_res0_valid,
   input  logic          i_res0_ready,
   output logic [PW-1:0] o_res0_p,
   output logic          o_res1_valid,
   input  logic          i_res1_ready,
   output logic [PW-1:0] o_res1_p,
   output logic          o_busy
);

   localparam int unsigned NREQ = 2;
   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam int unsigned AW   = $clog2(DEPTH);

   typedef struct packed {
      logic vld;
      logic id;
   } tag_t;

   logic [1:0]    r_mrst_sr;
   logic          r_rr;
   logic [CW-1:0] r_credit [NREQ];
   tag_t          r_tag    [LAT];
   logic [PW-1:0] r_mem    [NREQ][DEPTH];
   logic [AW:0]   r_wr     [NREQ];
   logic [AW:0]   r_rd     [NREQ];

   logic [NREQ-1:0] w_elig;
   logic [NREQ-1:0] w_gnt;
   logic [NREQ-1:0] w_push;
   logic [NREQ-1:0] w_pop;
   logic [NREQ-1:0] w_res_valid;
   logic [NREQ-1:0] w_res_ready;
   logic            w_busy;

   assign o_mul_rst   = r_mrst_sr[1];
   assign w_res_ready = {i_res1_ready, i_res0_ready};

   // Core reset held for two edges after release so the multiplier pipe is flushed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mrst_sr <= 2'b11;
      end else begin
         r_mrst_sr <= {r_mrst_sr[0], 1'b0};
      end
   end

   // Eligibility needs operands, a free result slot and a running core; rr_ptr breaks ties.
   always_comb begin
      w_elig    = '0;
      w_gnt     = '0;
      w_elig[0] = i_req0_valid && (r_credit[0] != '0) && !o_mul_rst;
      w_elig[1] = i_req1_valid && (r_credit[1] != '0) && !o_mul_rst;
      w_gnt[0]  = w_elig[0] && (!w_elig[1] || !r_rr);
      w_gnt[1]  = w_elig[1] && (!w_elig[0] ||  r_rr);
   end

   assign o_req0_ready = w_gnt[0];
   assign o_req1_ready = w_gnt[1];

   always_comb begin
      o_mul_x = '0;
      o_mul_y = '0;
      if (w_gnt[0]) begin
         o_mul_x = i_req0_x;
         o_mul_y = i_req0_y;
      end else if (w_gnt[1]) begin
         o_mul_x = i_req1_x;
         o_mul_y = i_req1_y;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr <= 1'b0;
      end else if (w_gnt[0]) begin
         r_rr <= 1'b1;
      end else if (w_gnt[1]) begin
         r_rr <= 1'b0;
      end
   end

   // Ownership tags travel alongside the operands through the multiplier latency.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < int'(LAT); k++) begin
            r_tag[k] <= '0;
         end
      end else begin
         r_tag[0].vld <= |w_gnt;
         r_tag[0].id  <= w_gnt[1];
         for (int k = 1; k < int'(LAT); k++) begin
            r_tag[k] <= r_tag[k-1];
         end
      end
   end

   always_comb begin
      w_push      = '0;
      w_res_valid = '0;
      w_pop       = '0;
      for (int n = 0; n < int'(NREQ); n++) begin
         w_push[n]      = r_tag[LAT-1].vld && (r_tag[LAT-1].id == 1'(n));
         w_res_valid[n] = (r_wr[n] != r_rd[n]);
         w_pop[n]       = w_res_valid[n] && w_res_ready[n];
      end
   end

   // Credits, FIFO pointers and storage per requester; credits bound FIFO occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int n = 0; n < int'(NREQ); n++) begin
            r_credit[n] <= CW'(DEPTH);
            r_wr[n]     <= '0;
            r_rd[n]     <= '0;
            for (int d = 0; d < int'(DEPTH); d++) begin
               r_mem[n][d] <= '0;
            end
         end
      end else begin
         for (int n = 0; n < int'(NREQ); n++) begin
            if (w_gnt[n] && !w_pop[n]) begin
               r_credit[n] <= r_credit[n] - CW'(1);
            end else if (!w_gnt[n] && w_pop[n]) begin
               r_credit[n] <= r_credit[n] + CW'(1);
            end
            if (w_push[n]) begin
               r_mem[n][r_wr[n][AW-1:0]] <= i_mul_p;
               r_wr[n]                   <= r_wr[n] + (AW+1)'(1);
            end
            if (w_pop[n]) begin
               r_rd[n] <= r_rd[n] + (AW+1)'(1);
            end
         end
      end
   end

   assign o_res0_valid = w_res_valid[0];
   assign o_res1_valid = w_res_valid[1];
   assign o_res0_p     = r_mem[0][r_rd[0][AW-1:0]];
   assign o_res1_p     = r_mem[1][r_rd[1][AW-1:0]];

   always_comb begin
      w_busy = |w_res_valid;
      for (int k = 0; k < int'(LAT); k++) begin
         w_busy = w_busy | r_tag[k].vld;
      end
   end

   assign o_busy = w_busy;

endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Directed + random bench for karatsuba_mul_arbiter with a behavioural multiplier and
// a queue-based reference model of grants, credits and per-requester result order.
module tb_karatsuba_mul_arbiter;

   localparam int unsigned XW    = 65;
   localparam int unsigned YW    = 64;
   localparam int unsigned PW    = 129;
   localparam int unsigned LAT   = 4;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [XW-1:0] req0_x, req1_x, mul_x;
   logic [YW-1:0] req0_y, req1_y, mul_y;
   logic          mul_rst;
   logic [PW-1:0] mul_p, res0_p, res1_p;
   logic          res0_valid, res0_ready, res1_valid, res1_ready, busy;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   karatsuba_mul_arbiter #(.XW(XW), .YW(YW), .PW(PW), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_x(req0_x), .i_req0_y(req0_y),
      .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_x(req1_x), .i_req1_y(req1_y),
      .o_mul_x(mul_x), .o_mul_y(mul_y), .o_mul_rst(mul_rst), .i_mul_p(mul_p),
      .o_res0_valid(res0_valid), .i_res0_ready(res0_ready), .o_res0_p(res0_p),
      .o_res1_valid(res1_valid), .i_res1_ready(res1_ready), .o_res1_p(res1_p),
      .o_busy(busy)
   );

   // Behavioural multiplier: LAT registers from input sample to P, sync active-high reset.
   logic [PW-1:0] m_stage [LAT];
   always @(posedge clk) begin
      if (mul_rst) begin
         for (int k = 0; k < int'(LAT); k++) m_stage[k] <= '0;
      end else begin
         m_stage[0] <= PW'(mul_x) * PW'(mul_y);
         for (int k = 1; k < int'(LAT); k++) m_stage[k] <= m_stage[k-1];
      end
   end
   assign mul_p = m_stage[LAT-1];

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   typedef struct {
      logic [PW-1:0] p;
      int            t;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];
   int   cyc = 0;
   int   post = 0;
   int   out0 = 0, out1 = 0;
   logic pref = 1'b0;
   int   n_iss0 = 0, n_iss1 = 0;
   logic sb_e0, sb_e1, sb_g0, sb_g1, sb_v0, sb_v1;
   logic [XW-1:0] sb_x;
   logic [YW-1:0] sb_y;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) post <= 0;
      else if (post < 2) post <= post + 1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_req0_ready", PW'(req0_ready), '0);
         check("rst_req1_ready", PW'(req1_ready), '0);
         check("rst_res0_valid", PW'(res0_valid), '0);
         check("rst_res1_valid", PW'(res1_valid), '0);
         check("rst_res0_p", res0_p, '0);
         check("rst_busy", PW'(busy), '0);
         check("rst_mul_rst", PW'(mul_rst), PW'(1));
         check("rst_mul_x", PW'(mul_x), '0);
         q0.delete();
         q1.delete();
         out0 = 0;
         out1 = 0;
         pref = 1'b0;
      end else begin
         sb_e0 = req0_valid && (out0 < int'(DEPTH)) && (post >= 2);
         sb_e1 = req1_valid && (out1 < int'(DEPTH)) && (post >= 2);
         sb_g0 = sb_e0 && (!sb_e1 || pref == 1'b0);
         sb_g1 = sb_e1 && (!sb_e0 || pref == 1'b1);
         sb_x  = sb_g0 ? req0_x : (sb_g1 ? req1_x : '0);
         sb_y  = sb_g0 ? req0_y : (sb_g1 ? req1_y : '0);
         check("mul_rst", PW'(mul_rst), PW'(post < 2));
         check("req0_ready", PW'(req0_ready), PW'(sb_g0));
         check("req1_ready", PW'(req1_ready), PW'(sb_g1));
         check("mul_x", PW'(mul_x), PW'(sb_x));
         check("mul_y", PW'(mul_y), PW'(sb_y));
         check("busy", PW'(busy), PW'((out0 + out1) != 0));
         sb_v0 = (q0.size() != 0) && (q0[0].t <= cyc);
         sb_v1 = (q1.size() != 0) && (q1[0].t <= cyc);
         check("res0_valid", PW'(res0_valid), PW'(sb_v0));
         check("res1_valid", PW'(res1_valid), PW'(sb_v1));
         if (sb_v0) check("res0_p", res0_p, q0[0].p);
         if (sb_v1) check("res1_p", res1_p, q1[0].p);
         if (req0_valid && req0_ready) n_iss0++;
         if (req1_valid && req1_ready) n_iss1++;
         if (sb_v0 && res0_ready) begin void'(q0.pop_front()); out0--; end
         if (sb_v1 && res1_ready) begin void'(q1.pop_front()); out1--; end
         if (sb_g0) begin
            q0.push_back('{p: PW'(req0_x) * PW'(req0_y), t: cyc + 1 + int'(LAT)});
            out0++;
            pref = 1'b1;
         end else if (sb_g1) begin
            q1.push_back('{p: PW'(req1_x) * PW'(req1_y), t: cyc + 1 + int'(LAT)});
            out1++;
            pref = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_ops();
      req0_x = XW'({$urandom(), $urandom(), $urandom()});
      req0_y = YW'({$urandom(), $urandom()});
      req1_x = XW'({$urandom(), $urandom(), $urandom()});
      req1_y = YW'({$urandom(), $urandom()});
   endtask

   task automatic drain();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res0_ready = 1'b1;
      res1_ready = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("drain_busy", PW'(busy), '0);
      step();
   endtask

   int a0, a1, lat;

   initial begin
      req0_valid = 1'b1; req0_x = XW'(3); req0_y = YW'(5);
      req1_valid = 1'b0; req1_x = '0; req1_y = '0;
      res0_ready = 1'b0; res1_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Release: two blocked cycles, then issue
      @(negedge clk); check("rel_c1_ready0", PW'(req0_ready), '0);
      @(negedge clk); check("rel_c2_ready0", PW'(req0_ready), '0);
      @(negedge clk); check("rel_c3_ready0", PW'(req0_ready), PW'(1));
      step();
      req0_valid = 1'b0;
      res0_ready = 1'b1;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (res0_valid) begin lat = k; break; end
      end
      check("single_latency", PW'(lat), PW'(LAT));
      check("single_res0_p", res0_p, PW'(15));
      check("single_res1_valid", PW'(res1_valid), '0);
      step();
      drain();

      // Contention: both streaming, results always accepted
      a0 = n_iss0; a1 = n_iss1;
      for (int k = 0; k < 40; k++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         rnd_ops();
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("cont_share0", PW'(n_iss0 - a0), PW'(20));
      check("cont_share1", PW'(n_iss1 - a1), PW'(20));
      drain();

      // Backpressure on requester 1 only
      res1_ready = 1'b0;
      a0 = n_iss0; a1 = n_iss1;
      for (int k = 0; k < 20; k++) begin
         req1_valid = 1'b1;
         req0_valid = 1'($urandom_range(0, 1));
         rnd_ops();
         step();
      end
      req0_valid = 1'b0;
      check("bp_issues1", PW'(n_iss1 - a1), PW'(DEPTH));
      check("bp_req0_progress", PW'((n_iss0 - a0) > 0), PW'(1));
      @(negedge clk);
      check("bp_ready1_low", PW'(req1_ready), '0);

      // Credit return: one pop frees one issue; issue+pop keeps the credit
      step();
      res1_ready = 1'b1;
      @(negedge clk);
      check("cr_a_ready1", PW'(req1_ready), '0);
      check("cr_a_res1_valid", PW'(res1_valid), PW'(1));
      step();
      @(negedge clk);
      check("cr_b_ready1", PW'(req1_ready), PW'(1));
      step();
      res1_ready = 1'b0;
      @(negedge clk);
      check("cr_c_ready1", PW'(req1_ready), PW'(1));
      step();
      @(negedge clk);
      check("cr_d_ready1", PW'(req1_ready), '0);
      step();
      drain();

      // Reset with three products in flight
      res0_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req0_valid = 1'b1;
         rnd_ops();
         step();
      end
      req0_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("mr_res0_valid", PW'(res0_valid), '0);
         check("mr_busy", PW'(busy), '0);
      end
      step();
      a0 = n_iss0;
      for (int k = 0; k < 15; k++) begin
         req0_valid = 1'b1;
         rnd_ops();
         step();
      end
      req0_valid = 1'b0;
      check("mr_credits_restored", PW'(n_iss0 - a0), PW'(DEPTH));
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
